data_memory: RTL
================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter AW, default 8, word-index width; memory depth 2^AW 32-bit words (1 KiB at default).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_ctrl_input  input  2  access control from pipeline MEM stage; bit1 = write, bit0 = read.
REQ-005 SHALL have port address  input  32  byte address of access.
REQ-006 SHALL have port w_data  input  32  store data.
REQ-007 SHALL have port read_data  output  32  load data, combinational, sampled by MEM stage at same rising edge.
REQ-008 SHALL have port ready  output  1  high when initialisation sweep complete and accesses are serviced.
REQ-009 SHALL have port err  output  1  sticky flag, set on any illegal access.
REQ-010 SHALL have port err_cnt  output  8  count of illegal accesses, saturating.

Function
REQ-011 SHALL implement FSM states CLEAR and READY; ready = 1 only in READY.
REQ-012 In CLEAR, SHALL write 32'd0 to word clr_ptr each cycle and increment clr_ptr (AW bits) from 0.
REQ-013 SHALL transition CLEAR -> READY on the edge that clears word 2^AW-1; ready rises exactly 2^AW edges after reset release (256 at default).
REQ-014 In CLEAR, SHALL ignore mem_ctrl_input (no write, no error count) and drive read_data = 32'd0.
REQ-015 An access is legal when READY, exactly one ctrl bit set, address[1:0] = 2'b00, and address[31:AW+2] = 0.
REQ-016 Illegal in READY: ctrl = 2'b11, misaligned address with any ctrl bit set, or out-of-range address with any ctrl bit set; ctrl = 2'b00 never illegal.
REQ-017 Legal read (ctrl = 2'b01): read_data = mem[address[AW+1:2]] combinationally, same cycle.
REQ-018 Legal write (ctrl = 2'b10): mem[address[AW+1:2]] <= w_data at the rising edge; read_data = 32'd0 during the write cycle.
REQ-019 A read of a word in the cycle after it was written SHALL return the new data.
REQ-020 Idle (2'b00) or illegal access: read_data = 32'd0, memory unchanged.
REQ-021 Illegal access: err <= 1 at the edge; err_cnt increments by 1, holds at 8'd255 (no wrap).
REQ-022 err and err_cnt SHALL clear only on reset.
REQ-023 Memory array SHALL NOT be asynchronously reset; zeroing is done only by the CLEAR sweep.

Reset
REQ-024 On reset_n low, immediately: state = CLEAR, clr_ptr = 0, ready = 0, err = 0, err_cnt = 0, read_data = 0.
REQ-025 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from word 0 on release; prior memory contents are not guaranteed.
REQ-026 No access issued before ready = 1 SHALL alter memory or error state.

Verification
REQ-027 Reset release, ctrl = 2'b10 held with address 0x10 -> ready low for 255 edges, high after edge 256; no error; word 4 reads 0 after ready.
REQ-028 Write 0xDEADBEEF to 0x3FC, next cycle read 0x3FC -> read_data = 0xDEADBEEF same cycle; read 0x000 -> 0x00000000.
REQ-029 ctrl = 2'b10, address 0x0000_0006 -> no write to word 1, err = 1, err_cnt = 1; ctrl = 2'b11, address 0x8 -> err_cnt = 2, word 2 unchanged.
REQ-030 Read address 0x0000_0400 (out of range at AW = 8) -> read_data = 0, err_cnt increments.
REQ-031 300 consecutive illegal accesses -> err_cnt = 255, err = 1; reset -> both 0, ready 0.
REQ-032 Reset pulse at sweep word 100, release -> ready rises 256 edges after second release; all words read 0.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: 2^AW x 32-bit word-addressed data memory for the pipeline MEM stage.
// After reset a CLEAR sweep zeroes every word, one per cycle. Accesses are ignored
// until the sweep finishes. Reads are combinational and writes take effect on the
// rising edge. Illegal accesses set a sticky error flag and bump a saturating counter.
module data_memory #(
    parameter int AW = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_ctrl_input,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int        DEPTH   = 1 << AW;
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    // Storage has no reset; the CLEAR sweep is the only zeroing mechanism.
    logic [31:0]   mem_q [DEPTH];

    logic [0:0]    state_q,   state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic          err_q,     err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic [AW-1:0] word_idx_s;
    logic          aligned_s;
    logic          in_range_s;
    logic          is_ready_s;
    logic          legal_rd_s;
    logic          legal_wr_s;
    logic          illegal_s;

    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [31:0]   mem_wdata_s;

    // Decode the access and classify it as a legal read, legal write or illegal.
    always_comb begin
        word_idx_s = address[AW+1:2];
        aligned_s  = (address[1:0] == 2'b00);
        in_range_s = (address[31:AW+2] == {(30-AW){1'b0}});
        is_ready_s = (state_q == S_READY);
        legal_rd_s = is_ready_s && (mem_ctrl_input == 2'b01) && aligned_s && in_range_s;
        legal_wr_s = is_ready_s && (mem_ctrl_input == 2'b10) && aligned_s && in_range_s;
        // Idle (2'b00) is never an error; anything else that is not legal is.
        illegal_s  = is_ready_s && (mem_ctrl_input != 2'b00) && !(legal_rd_s || legal_wr_s);
    end

    // Next-state logic for the sweep FSM, clear pointer and error tracking.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_CLEAR: begin
                clr_ptr_d = clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
                // Leave CLEAR on the same edge that zeroes the last word.
                if (clr_ptr_q == {AW{1'b1}}) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d   = S_CLEAR;
                clr_ptr_d = {AW{1'b0}};
            end
        endcase
        if (illegal_s) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_d     = err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Select the single memory write port source: sweep zeroing or a legal store.
    always_comb begin
        if (state_q == S_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_ptr_q;
            mem_wdata_s = 32'd0;
        end else if (legal_wr_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = word_idx_s;
            mem_wdata_s = w_data;
        end else begin
            mem_we_s    = 1'b0;
            mem_waddr_s = word_idx_s;
            mem_wdata_s = w_data;
        end
    end

    // Combinational load path: data only for a legal read, zero otherwise.
    always_comb begin
        if (legal_rd_s) begin
            read_data = mem_q[word_idx_s];
        end else begin
            read_data = 32'd0;
        end
    end

    // Control and error state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= {AW{1'b0}};
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Memory array write port, intentionally without reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign ready   = (state_q == S_READY);
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule
